hazard_ctrl: RTL and testbench

Pipeline hazard and sequencing controller for the five-stage ARM-subset CPU. Drives the enable and flush/bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. Handles three cases: load-use stalls, taken-branch flushes and multi-cycle data-memory freezes. Also keeps a memory-wait watchdog and saturating stall/flush performance counters.

---
 rtl/hazard_ctrl_pkg.sv | 12 +
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_ctrl_sat_counter.sv | 25 ++
 rtl/hazard_ctrl.sv | 159 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard/sequencing controller.
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN     = 2'd0,
    FREEZE  = 2'd1,
    RECOVER = 2'd2
  } ctrl_state_t;

  localparam logic [4:0] XZR = 5'd31;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side hazard inputs and the controller's enable/flush/status outputs.
interface hazard_ctrl_if #(
  parameter int CNT_W = 32
);
  logic [4:0]       Rn_id;
  logic [4:0]       Rm_id;
  logic             use_rn_id;
  logic             use_rm_id;
  logic [4:0]       Rd_ex;
  logic             MemtoReg_ex;
  logic             RegWrite_ex;
  logic             br_taken_ex;
  logic             dmem_busy;
  logic             pc_en;
  logic             if_id_en;
  logic             if_id_flush;
  logic             id_ex_bubble;
  logic             back_en;
  logic             err_timeout;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;
  logic [1:0]       state;

  modport master (
    output Rn_id, Rm_id, use_rn_id, use_rm_id, Rd_ex, MemtoReg_ex, RegWrite_ex,
           br_taken_ex, dmem_busy,
    input  pc_en, if_id_en, if_id_flush, id_ex_bubble, back_en, err_timeout,
           stall_cnt, flush_cnt, state
  );

  modport slave (
    input  Rn_id, Rm_id, use_rn_id, use_rm_id, Rd_ex, MemtoReg_ex, RegWrite_ex,
           br_taken_ex, dmem_busy,
    output pc_en, if_id_en, if_id_flush, id_ex_bubble, back_en, err_timeout,
           stall_cnt, flush_cnt, state
  );
endinterface

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear,
  input  logic         inc,
  output logic [W-1:0] count
);

  // count register: clear wins over increment, increment stops at all-ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= {W{1'b0}};
    end else if (clear) begin
      count <= {W{1'b0}};
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end else begin
      count <= count;
    end
  end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller: load-use stalls, branch flushes, data-memory freezes,
// memory-wait watchdog and stall/flush performance counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int MAX_WAIT = 15
) (
  input logic          clk,
  input logic          reset,
  hazard_ctrl_if.slave hif
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  ctrl_state_t       state_r;
  ctrl_state_t       state_next_s;
  logic              pend_r;
  logic              pend_next_s;
  logic [WAIT_W-1:0] wait_r;
  logic              err_r;
  logic              lu_s;
  logic              pc_en_s;
  logic              if_id_en_s;
  logic              if_id_flush_s;
  logic              id_ex_bubble_s;
  logic              back_en_s;

  assign lu_s = hif.MemtoReg_ex && hif.RegWrite_ex && (hif.Rd_ex != XZR) &&
                ((hif.use_rn_id && (hif.Rn_id == hif.Rd_ex)) ||
                 (hif.use_rm_id && (hif.Rm_id == hif.Rd_ex)));

  // next-state and Mealy controls; freeze outranks flush, flush outranks load-use
  always_comb begin
    state_next_s   = state_r;
    pend_next_s    = pend_r;
    pc_en_s        = 1'b0;
    if_id_en_s     = 1'b0;
    if_id_flush_s  = 1'b0;
    id_ex_bubble_s = 1'b0;
    back_en_s      = 1'b0;
    if (!reset) begin
      state_next_s = RUN;
      pend_next_s  = 1'b0;
    end else begin
      case (state_r)
        RUN, FREEZE: begin
          if (hif.dmem_busy) begin
            state_next_s = FREEZE;
            if (hif.br_taken_ex) begin
              pend_next_s = 1'b1;
            end else begin
              pend_next_s = pend_r;
            end
          end else begin
            if (hif.br_taken_ex) begin
              pc_en_s        = 1'b1;
              if_id_en_s     = 1'b1;
              back_en_s      = 1'b1;
              if_id_flush_s  = 1'b1;
              id_ex_bubble_s = 1'b1;
            end else if (lu_s) begin
              id_ex_bubble_s = 1'b1;
              back_en_s      = 1'b1;
            end else begin
              pc_en_s    = 1'b1;
              if_id_en_s = 1'b1;
              back_en_s  = 1'b1;
            end
            // a branch caught during the freeze is replayed in its own cycle
            if ((state_r == FREEZE) && pend_r) begin
              state_next_s = RECOVER;
            end else begin
              state_next_s = RUN;
            end
          end
        end
        RECOVER: begin
          if (hif.dmem_busy) begin
            state_next_s = FREEZE;
            pend_next_s  = 1'b1;
          end else begin
            pc_en_s        = 1'b1;
            if_id_en_s     = 1'b1;
            back_en_s      = 1'b1;
            if_id_flush_s  = 1'b1;
            id_ex_bubble_s = 1'b1;
            pend_next_s    = 1'b0;
            state_next_s   = RUN;
          end
        end
        default: begin
          state_next_s = RUN;
          pend_next_s  = 1'b0;
        end
      endcase
    end
  end

  // FSM state and pending-flush registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= RUN;
      pend_r  <= 1'b0;
    end else begin
      state_r <= state_next_s;
      pend_r  <= pend_next_s;
    end
  end

  // memory-wait watchdog: counts consecutive busy cycles, error flag is sticky
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_r <= {WAIT_W{1'b0}};
      err_r  <= 1'b0;
    end else if (hif.dmem_busy) begin
      if (wait_r != WAIT_MAX) begin
        wait_r <= wait_r + WAIT_W'(1);
      end else begin
        wait_r <= wait_r;
      end
      if (wait_r >= WAIT_LAST) begin
        err_r <= 1'b1;
      end else begin
        err_r <= err_r;
      end
    end else begin
      wait_r <= {WAIT_W{1'b0}};
      err_r  <= err_r;
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clear (1'b0),
    .inc   (!pc_en_s),
    .count (hif.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .clear (1'b0),
    .inc   (if_id_flush_s),
    .count (hif.flush_cnt)
  );

  assign hif.pc_en        = pc_en_s;
  assign hif.if_id_en     = if_id_en_s;
  assign hif.if_id_flush  = if_id_flush_s;
  assign hif.id_ex_bubble = id_ex_bubble_s;
  assign hif.back_en      = back_en_s;
  assign hif.err_timeout  = err_r;
  assign hif.state        = state_r;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Randomized + directed bench for hazard_ctrl against a cycle-level behavioural model.
module tb_hazard_ctrl;

  localparam int CNT_W    = 32;
  localparam int MAX_WAIT = 15;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  hazard_ctrl_if #(.CNT_W(CNT_W)) hif ();

  hazard_ctrl #(.CNT_W(CNT_W), .MAX_WAIT(MAX_WAIT)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // model: "in a freeze", "recovery cycle owed", "branch remembered while frozen"
  bit     m_frozen;
  bit     m_recover;
  bit     m_pend;
  bit     m_err;
  int     m_wait;
  longint m_stall;
  longint m_flush;
  longint cnt_max;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_frozen  = 1'b0;
    m_recover = 1'b0;
    m_pend    = 1'b0;
    m_err     = 1'b0;
    m_wait    = 0;
    m_stall   = 0;
    m_flush   = 0;
  endtask

  // one clock cycle, entered and left aligned to a falling edge
  task automatic cyc(input logic [4:0] rn, input logic [4:0] rm, input logic urn, input logic urm,
                     input logic [4:0] rd, input logic mtr, input logic rw,
                     input logic br, input logic busy);
    bit lu;
    bit e_pc, e_ifid, e_fl, e_bub, e_back;
    int e_state;
    hif.Rn_id = rn; hif.Rm_id = rm; hif.use_rn_id = urn; hif.use_rm_id = urm;
    hif.Rd_ex = rd; hif.MemtoReg_ex = mtr; hif.RegWrite_ex = rw;
    hif.br_taken_ex = br; hif.dmem_busy = busy;
    #1;
    lu = mtr && rw && (rd != 5'd31) && ((urn && rn == rd) || (urm && rm == rd));
    e_state = m_recover ? 2 : (m_frozen ? 1 : 0);
    if (busy) begin
      {e_pc, e_ifid, e_fl, e_bub, e_back} = 5'b00000;
    end else if (m_recover || br) begin
      {e_pc, e_ifid, e_fl, e_bub, e_back} = 5'b11111;
    end else if (lu) begin
      {e_pc, e_ifid, e_fl, e_bub, e_back} = 5'b00011;
    end else begin
      {e_pc, e_ifid, e_fl, e_bub, e_back} = 5'b11001;
    end
    check_eq("state",        64'(hif.state),        64'(e_state));
    check_eq("stall_cnt",    64'(hif.stall_cnt),    64'(m_stall));
    check_eq("flush_cnt",    64'(hif.flush_cnt),    64'(m_flush));
    check_eq("err_timeout",  64'(hif.err_timeout),  64'(m_err));
    check_eq("pc_en",        64'(hif.pc_en),        64'(e_pc));
    check_eq("if_id_en",     64'(hif.if_id_en),     64'(e_ifid));
    check_eq("if_id_flush",  64'(hif.if_id_flush),  64'(e_fl));
    check_eq("id_ex_bubble", 64'(hif.id_ex_bubble), 64'(e_bub));
    check_eq("back_en",      64'(hif.back_en),      64'(e_back));
    if (busy) begin
      m_pend    = m_pend | br;
      m_frozen  = 1'b1;
      m_recover = 1'b0;
      if (m_wait < MAX_WAIT) m_wait++;
      if (m_wait == MAX_WAIT) m_err = 1'b1;
    end else begin
      m_wait = 0;
      if (m_recover) begin
        m_pend    = 1'b0;
        m_recover = 1'b0;
      end else begin
        m_recover = m_frozen && m_pend;
        if (!m_recover) m_pend = m_pend;
      end
      m_frozen = 1'b0;
    end
    if (!e_pc && m_stall < cnt_max) m_stall++;
    if (e_fl && m_flush < cnt_max) m_flush++;
    @(negedge clk);
  endtask

  task automatic idle(input bit busy);
    cyc(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b0, busy);
  endtask

  // async reset from a falling edge; outputs must drop while inputs stay as they were
  task automatic do_reset();
    #1 reset = 1'b0;
    #1;
    check_eq("rst_pc_en",  64'(hif.pc_en),  64'd0);
    check_eq("rst_if_id_en", 64'(hif.if_id_en), 64'd0);
    check_eq("rst_back_en",  64'(hif.back_en),  64'd0);
    check_eq("rst_flush",  64'({hif.if_id_flush, hif.id_ex_bubble}), 64'd0);
    check_eq("rst_state",  64'(hif.state),  64'd0);
    check_eq("rst_cnts",   64'(hif.stall_cnt) + 64'(hif.flush_cnt), 64'd0);
    check_eq("rst_err",    64'(hif.err_timeout), 64'd0);
    model_reset();
    hif.dmem_busy = 1'b0;
    hif.br_taken_ex = 1'b0;
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    int burst;
    cnt_max = (longint'(1) << CNT_W) - 1;
    model_reset();
    hif.Rn_id = 5'd0; hif.Rm_id = 5'd0; hif.use_rn_id = 1'b0; hif.use_rm_id = 1'b0;
    hif.Rd_ex = 5'd0; hif.MemtoReg_ex = 1'b0; hif.RegWrite_ex = 1'b0;
    hif.br_taken_ex = 1'b0; hif.dmem_busy = 1'b0;
    @(negedge clk);
    do_reset();

    // load-use on Rn, then the same against XZR
    cyc(5'd2, 5'd7, 1'b1, 1'b0, 5'd2, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(1'b0);
    check_eq("lu_stall_cnt", 64'(hif.stall_cnt), 64'd1);
    cyc(5'd31, 5'd7, 1'b1, 1'b0, 5'd31, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc(5'd4, 5'd9, 1'b0, 1'b1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0);
    // taken branch while running
    cyc(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b0);
    idle(1'b0);
    check_eq("br_flush_cnt", 64'(hif.flush_cnt), 64'd1);
    // four busy cycles with a branch in the second, then RECOVER
    idle(1'b1);
    cyc(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    idle(1'b1);
    idle(1'b1);
    idle(1'b0);
    idle(1'b0);
    idle(1'b0);
    // load-use together with branch, then with busy
    cyc(5'd6, 5'd6, 1'b1, 1'b1, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc(5'd6, 5'd6, 1'b1, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(1'b0);
    // watchdog: 14 busy cycles leave it clear, the 15th trips it
    for (int i = 0; i < MAX_WAIT - 1; i++) idle(1'b1);
    check_eq("wd_not_yet", 64'(hif.err_timeout), 64'd0);
    idle(1'b1);
    check_eq("wd_tripped", 64'(hif.err_timeout), 64'd1);
    idle(1'b0);
    idle(1'b0);
    check_eq("wd_sticky", 64'(hif.err_timeout), 64'd1);
    // reset in the middle of a freeze with a pending flush
    idle(1'b1);
    cyc(5'd1, 5'd2, 1'b0, 1'b0, 5'd3, 1'b0, 1'b0, 1'b1, 1'b1);
    hif.dmem_busy = 1'b1;
    do_reset();
    idle(1'b0);
    idle(1'b0);
    check_eq("post_rst_flush", 64'(hif.flush_cnt), 64'd0);

    // randomized traffic with busy bursts, branches and register matches
    burst = 0;
    for (int n = 0; n < 3000; n++) begin
      logic busy;
      if (burst > 0) begin
        busy = 1'b1;
        burst--;
      end else if ($urandom_range(0, 7) == 0) begin
        busy = 1'b1;
        burst = $urandom_range(0, 18);
      end else begin
        busy = 1'b0;
      end
      if (n == 1700) begin
        do_reset();
      end
      cyc(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
          ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 7)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 4) == 0), busy);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
